if_fetch_ctrl: RTL

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/if_fetch_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction fetch controller.
// It holds a word-address PC into an instruction memory of IM_DEPTH words.
// The memory answers combinationally, and each instruction is handed to
// decode through a registered valid/ready stage.
// A fetched HALT_WORD stops fetch until a branch redirect arrives.
// Optional feature: define IF_PERF_CNT_EN to add the fetch_cnt output.
// That output is a saturating count of instructions accepted by decode.
module if_fetch_ctrl #(
    parameter int unsigned IM_DEPTH  = 128,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        IFclk,
    input  logic        IFrst_n,
    input  logic        start,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_valid,
    input  logic        id_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    localparam logic [31:0] DEPTH = 32'(IM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] id_inst_q;
    logic [31:0] id_pc_q;
    logic        id_valid_q;
    logic        halted_q;

    logic        advance_d;
    logic [31:0] pc_inc_d;
    logic [31:0] br_pc_d;

    // Next-PC candidates and the pipeline advance condition
    always_comb begin
        advance_d = !id_valid_q || id_ready;
        pc_inc_d  = (pc_q == DEPTH - 32'd1) ? '0 : pc_q + 32'd1;
        br_pc_d   = br_target % DEPTH;
    end

    // Fetch FSM with registered PC, decode-stage outputs and halt flag
    always_ff @(posedge IFclk or negedge IFrst_n) begin
        if (!IFrst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A redirect takes priority over stall, advance and halt detection
                    if (br_taken) begin
                        pc_q       <= br_pc_d;
                        id_valid_q <= 1'b0;
                    end else if (advance_d) begin
                        if (inst == HALT_WORD) begin
                            id_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                            state_q    <= S_HALT;
                        end else begin
                            id_inst_q  <= inst;
                            id_pc_q    <= pc_q;
                            id_valid_q <= 1'b1;
                            pc_q       <= pc_inc_d;
                        end
                    end
                end
                S_HALT: begin
                    if (br_taken) begin
                        pc_q       <= br_pc_d;
                        id_valid_q <= 1'b0;
                        halted_q   <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Saturating count of instructions handed to decode
    always_ff @(posedge IFclk or negedge IFrst_n) begin
        if (!IFrst_n) begin
            fetch_cnt_q <= '0;
        end else if (id_valid_q && id_ready && (fetch_cnt_q != '1)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`endif

    assign inst_addr = pc_q;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;
    assign id_valid  = id_valid_q;
    assign halted    = halted_q;

endmodule
